// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor encoding, dispatcher states and n_stage layout.
package elevator_pkg;

  localparam int FLOOR_W   = 2;
  localparam int N_FLOORS  = 4;
  localparam int VALID_BIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } disp_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One floor button: 2-flop synchroniser, hold-time debouncer and rising-edge press pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] count_q, count_d;
  logic            count_done;

  assign count_done = (count_q == DB_W'(DB_CYCLES - 1));

  always_comb begin
    level_d = level_q;
    count_d = '0;
    if (sync2_q != level_q) begin
      if (count_done) begin
        level_d = sync2_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Pulse in the cycle the accepted level flips to 1, so pending latches on the same edge.
  assign press = sync2_q & ~level_q & count_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/call_dispatcher.sv
// Latches floor calls, picks the next target by direction and hands it to the
// memory manager over a 4-phase req/ack pair.
module call_dispatcher
  import elevator_pkg::*;
#(
  parameter int DB_CYCLES = 50000,
  parameter int DB_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]  current_floor,
  input  logic                ud_dir,
  input  logic                exit,
  input  logic                ns_done,
  output logic [2:0]          n_stage,
  output logic                ns_req,
  output logic [N_FLOORS-1:0] pending
);

  logic [N_FLOORS-1:0] press;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [N_FLOORS-1:0] inflight_q, inflight_d;
  logic [N_FLOORS-1:0] avail, exit_hit;
  logic [2:0]          n_stage_q, n_stage_d;
  logic                ns_req_q, ns_req_d;
  disp_state_t         state_q, state_d;

  logic                above_found, below_found, cand;
  logic [FLOOR_W-1:0]  above_sel, below_sel, sel;

  genvar gi;
  generate
    for (gi = 0; gi < N_FLOORS; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
      ) u_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  assign avail    = pending_q & ~inflight_q;
  assign exit_hit = exit ? (N_FLOORS'(1) << current_floor) : '0;

  always_comb begin
    above_found = 1'b0;
    below_found = 1'b0;
    above_sel   = '0;
    below_sel   = '0;
    // Descending scan leaves the lowest floor above; ascending leaves the highest below.
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (avail[i] && (FLOOR_W'(i) > current_floor)) begin
        above_found = 1'b1;
        above_sel   = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (avail[i] && (FLOOR_W'(i) < current_floor)) begin
        below_found = 1'b1;
        below_sel   = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    sel = current_floor;
    if (ud_dir) begin
      if (above_found)      sel = above_sel;
      else if (below_found) sel = below_sel;
    end else begin
      if (below_found)      sel = below_sel;
      else if (above_found) sel = above_sel;
    end
  end

  assign cand = above_found | below_found | avail[current_floor];

  always_comb begin
    pending_d  = press | (pending_q & ~exit_hit);
    inflight_d = inflight_q & pending_d & ~exit_hit;
    state_d    = state_q;
    n_stage_d  = n_stage_q;
    ns_req_d   = ns_req_q;
    case (state_q)
      IDLE: begin
        if (cand && !ns_done) begin
          n_stage_d                 = '0;
          n_stage_d[VALID_BIT]      = 1'b1;
          n_stage_d[FLOOR_W-1:0]    = sel;
          inflight_d                = N_FLOORS'(1) << sel;
          ns_req_d                  = 1'b1;
          state_d                   = REQ;
        end
      end
      REQ: begin
        if (ns_done) begin
          ns_req_d = 1'b0;
          state_d  = REL;
        end
      end
      REL: begin
        if (!ns_done) begin
          n_stage_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        n_stage_d = '0;
        ns_req_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      n_stage_q  <= '0;
      ns_req_q   <= 1'b0;
      pending_q  <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      n_stage_q  <= n_stage_d;
      ns_req_q   <= ns_req_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
    end
  end

  assign n_stage = n_stage_q;
  assign ns_req  = ns_req_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_call_dispatcher.sv
// Directed bench: expected dispatches are queued by the stimulus, a monitor checks each request.
module tb_call_dispatcher;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic [1:0] current_floor = 2'd0;
  logic       ud_dir = 1'b1;
  logic       exit = 1'b0;
  logic       ns_done = 1'b0;
  logic [2:0] n_stage;
  logic       ns_req;
  logic [3:0] pending;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  call_dispatcher #(
    .DB_CYCLES (4),
    .DB_W      (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .current_floor (current_floor),
    .ud_dir        (ud_dir),
    .exit          (exit),
    .ns_done       (ns_done),
    .n_stage       (n_stage),
    .ns_req        (ns_req),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Waits for a request, acks it after dly clocks, then completes the release phase.
  task automatic handshake(input int dly);
    int n;
    n = 0;
    while (!ns_req && n < 40) begin tick(); n++; end
    if (!ns_req) check("req_timeout", 8'(ns_req), 8'd1);
    repeat (dly) tick();
    ns_done = 1'b1;
    n = 0;
    while (ns_req && n < 10) begin tick(); n++; end
    if (ns_req) check("ack_timeout", 8'(ns_req), 8'd0);
    ns_done = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: every new request pops one expected n_stage; held requests must stay stable.
  logic       req_prev = 1'b0;
  logic [2:0] stage_prev = 3'b000;
  always @(posedge clk) begin
    logic [2:0] e;
    #2;
    if (ns_req && !req_prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL dispatch: got n_stage=%b expected no request", n_stage);
      end else begin
        e = exp_q.pop_front();
        if (n_stage !== e) begin
          bad++;
          $display("FAIL dispatch: got n_stage=%b expected %b", n_stage, e);
        end else begin
          $display("ok   dispatch: n_stage=%b", n_stage);
        end
      end
    end else if (ns_req && req_prev) begin
      total++;
      if (n_stage !== stage_prev) begin
        bad++;
        $display("FAIL stable: got n_stage=%b expected %b", n_stage, stage_prev);
      end
    end
    req_prev   = ns_req;
    stage_prev = n_stage;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with all buttons held
    btn = 4'b1111;
    repeat (3) tick();
    check("rst_pending", 8'(pending), 8'h0);
    check("rst_req", 8'(ns_req), 8'h0);
    check("rst_stage", 8'(n_stage), 8'h0);
    btn = 4'b0000;
    tick();
    reset = 1'b0;
    repeat (15) tick();
    check("idle_pending", 8'(pending), 8'h0);
    check("idle_req", 8'(ns_req), 8'h0);

    // 2: clean press of floor 2 from floor 0 going up
    current_floor = 2'd0;
    ud_dir = 1'b1;
    exp_q.push_back(3'b110);
    btn[2] = 1'b1;
    repeat (5) tick();
    check("lat_before", 8'(pending), 8'h0);
    tick();
    check("lat_at6", 8'(pending), 8'h4);
    tick();
    check("req_up", 8'(ns_req), 8'h1);
    repeat (3) tick();
    ns_done = 1'b1;
    tick();
    check("req_drop", 8'(ns_req), 8'h0);
    check("rel_stage", 8'(n_stage), 8'h6);
    ns_done = 1'b0;
    tick();
    check("stage_clr", 8'(n_stage), 8'h0);
    btn[2] = 1'b0;
    repeat (8) tick();
    current_floor = 2'd2;
    exit = 1'b1;
    tick();
    exit = 1'b0;
    check("exit_clr2", 8'(pending), 8'h0);

    // 3: bouncing button 1 yields exactly one press
    for (int k = 0; k < 10; k++) begin
      btn[1] = ~btn[1];
      tick();
      tick();
    end
    check("bounce_none", 8'(pending), 8'h0);
    exp_q.push_back(3'b101);
    btn[1] = 1'b1;
    handshake(2);
    check("bounce_one", 8'(pending), 8'h2);
    current_floor = 2'd1;
    exit = 1'b1;
    tick();
    exit = 1'b0;
    check("exit_clr1", 8'(pending), 8'h0);
    repeat (10) tick();
    check("held_once", 8'(pending), 8'h0);
    btn[1] = 1'b0;
    repeat (8) tick();

    // 4/6: stale ack blocks dispatch; up-direction pick; reset mid-request
    ns_done = 1'b1;
    btn = 4'b1011;
    repeat (8) tick();
    btn = 4'b0000;
    repeat (10) tick();
    check("stale_pend", 8'(pending), 8'hB);
    check("stale_noreq", 8'(ns_req), 8'h0);
    current_floor = 2'd1;
    ud_dir = 1'b1;
    exp_q.push_back(3'b111);
    ns_done = 1'b0;
    repeat (4) tick();
    check("up_req", 8'(ns_req), 8'h1);
    reset = 1'b1;
    #1;
    check("async_req", 8'(ns_req), 8'h0);
    check("async_pend", 8'(pending), 8'h0);
    ns_done = 1'b1;
    btn = 4'b1011;
    ud_dir = 1'b0;
    tick();
    reset = 1'b0;
    repeat (12) tick();
    check("post_rst_pend", 8'(pending), 8'hB);
    check("post_rst_noreq", 8'(ns_req), 8'h0);
    btn = 4'b0000;
    exp_q.push_back(3'b100);
    ns_done = 1'b0;
    repeat (3) tick();
    check("down_req", 8'(ns_req), 8'h1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();

    // 5: exit coinciding with a new press on the same floor
    current_floor = 2'd3;
    ud_dir = 1'b1;
    exp_q.push_back(3'b111);
    btn[3] = 1'b1;
    handshake(1);
    btn[3] = 1'b0;
    repeat (8) tick();
    check("pre5_pend", 8'(pending), 8'h8);
    exp_q.push_back(3'b111);
    btn[3] = 1'b1;
    repeat (5) tick();
    exit = 1'b1;
    tick();
    exit = 1'b0;
    check("press_wins", 8'(pending), 8'h8);
    handshake(1);
    btn[3] = 1'b0;
    repeat (8) tick();
    exit = 1'b1;
    tick();
    exit = 1'b0;
    check("exit_alone", 8'(pending), 8'h0);
    repeat (10) tick();
    check("no_redispatch", 8'(ns_req), 8'h0);

    check("queue_empty", 8'(exp_q.size()), 8'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
